// File: rtl/sd_resp_pkg.sv
// Shared types and constants for the sd_block_responder sector target.
package sd_resp_pkg;

  localparam int BLK_BYTES = 512;
  localparam int BLK_AW    = 9;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ACK,
    RD_MEM,
    RD_PUT,
    WR_FETCH,
    WR_CAP,
    WR_MEM,
    DONE
  } state_t;

endpackage

// File: rtl/sd_block_responder.sv
// Target side of the hps_io sector handshake. Serves one 512-byte block per
// sd_rd/sd_wr request from a byte-wide backing store and announces image
// mounts with a one-cycle img_mounted pulse.
module sd_block_responder
  import sd_resp_pkg::*;
#(
  parameter int MEM_AW    = 24,
  parameter int ACK_DELAY = 4
) (
  input  logic              clk_sys,
  input  logic              RESET_n,
  input  logic              img_present,
  input  logic              img_ro_in,
  input  logic [63:0]       img_bytes,
  output logic              img_mounted,
  output logic              img_readonly,
  output logic [63:0]       img_size,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_din,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic              err_range
);

  localparam int CNT_W = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
  localparam int LBA_W = MEM_AW - BLK_AW;

  state_t            state, state_nx;
  logic [BLK_AW-1:0] idx;
  logic [CNT_W-1:0]  cnt;
  logic [LBA_W-1:0]  lba_q;
  logic              dir_rd;
  logic              in_rng;
  logic [7:0]        data;
  logic              present_q;
  logic              mount_pend;

  logic req, rng_ok, last_byte;
  logic img_rise, img_fall, do_mount;
  logic accept, ack_set, ack_clr, idx_inc, cnt_inc;
  logic ld_rdata, ld_zero, ld_din;

  // Request qualification and mount edge detection.
  always_comb begin
    req       = sd_rd | sd_wr;
    // A partial trailing block is treated as out of range.
    rng_ok    = 55'(sd_lba) < img_size[63:9];
    last_byte = (idx == BLK_AW'(BLK_BYTES - 1));
    img_rise  = img_present & ~present_q;
    img_fall  = ~img_present & present_q;
    // Mount announcements are held back while a block is in flight.
    do_mount  = (img_rise | (mount_pend & ~img_fall)) & ~sd_ack;
  end

  // FSM state register.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) state <= IDLE;
    else          state <= state_nx;
  end

  // FSM next-state, strobes and datapath controls.
  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    ack_set    = 1'b0;
    ack_clr    = 1'b0;
    idx_inc    = 1'b0;
    cnt_inc    = 1'b0;
    ld_rdata   = 1'b0;
    ld_zero    = 1'b0;
    ld_din     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    sd_buff_wr = 1'b0;
    case (state)
      IDLE: begin
        // With no image the request is left pending and never acked.
        if (req && (img_size != 64'd0)) begin
          accept   = 1'b1;
          state_nx = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (cnt == CNT_W'(ACK_DELAY - 1)) begin
          ack_set  = 1'b1;
          state_nx = dir_rd ? RD_MEM : WR_FETCH;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RD_MEM: begin
        if (!in_rng) begin
          ld_zero  = 1'b1;
          state_nx = RD_PUT;
        end else begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            ld_rdata = 1'b1;
            state_nx = RD_PUT;
          end
        end
      end
      RD_PUT: begin
        sd_buff_wr = 1'b1;
        if (last_byte) state_nx = DONE;
        else begin
          idx_inc  = 1'b1;
          state_nx = RD_MEM;
        end
      end
      WR_FETCH: state_nx = WR_CAP;
      WR_CAP: begin
        // Buffer data arrives one cycle after the address was presented.
        ld_din   = 1'b1;
        state_nx = WR_MEM;
      end
      WR_MEM: begin
        if (in_rng && !img_readonly) begin
          mem_wr = 1'b1;
          if (mem_ready) begin
            if (last_byte) state_nx = DONE;
            else begin
              idx_inc  = 1'b1;
              state_nx = WR_FETCH;
            end
          end
        end else begin
          // Byte is discarded but the handshake still runs its full length.
          if (last_byte) state_nx = DONE;
          else begin
            idx_inc  = 1'b1;
            state_nx = WR_FETCH;
          end
        end
      end
      DONE: begin
        ack_clr  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, ack, byte index, ack-delay counter and data byte.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      lba_q  <= '0;
      dir_rd <= 1'b0;
      in_rng <= 1'b0;
      cnt    <= '0;
      idx    <= '0;
      sd_ack <= 1'b0;
      data   <= 8'h00;
    end else begin
      if (accept) begin
        // Upper lba bits beyond the store width are dropped silently.
        lba_q  <= sd_lba[LBA_W-1:0];
        dir_rd <= sd_rd;
        in_rng <= rng_ok;
        cnt    <= '0;
      end
      if (cnt_inc) cnt <= cnt + 1'b1;
      if (ack_set) begin
        sd_ack <= 1'b1;
        idx    <= '0;
      end
      if (ack_clr) sd_ack <= 1'b0;
      if (idx_inc) idx <= idx + 1'b1;
      if (ld_rdata)     data <= mem_rdata;
      else if (ld_zero) data <= 8'h00;
      else if (ld_din)  data <= sd_buff_din;
    end
  end

  // Image mount tracking and sticky range error.
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      present_q    <= 1'b0;
      mount_pend   <= 1'b0;
      img_mounted  <= 1'b0;
      img_readonly <= 1'b0;
      img_size     <= 64'd0;
      err_range    <= 1'b0;
    end else begin
      present_q   <= img_present;
      img_mounted <= 1'b0;
      mount_pend  <= (img_rise | mount_pend) & ~img_fall & sd_ack;
      if (do_mount) begin
        img_mounted  <= 1'b1;
        img_size     <= img_bytes;
        img_readonly <= img_ro_in;
        err_range    <= 1'b0;
      end
      if (img_fall) img_size <= 64'd0;
      if (accept && !rng_ok) err_range <= 1'b1;
    end
  end

  assign sd_buff_addr = idx;
  assign sd_buff_dout = data;
  assign mem_wdata    = data;
  assign mem_addr     = {lba_q, idx};

endmodule

// File: tb/tb_sd_block_responder.sv
// Directed bench for sd_block_responder: table of block transfers plus
// hand-written sequences for back-to-back, reset abort and deferred mount.
module tb_sd_block_responder;

  localparam int MEM_AW    = 24;
  localparam int ACK_DELAY = 4;

  logic              clk_sys, RESET_n;
  logic              img_present, img_ro_in;
  logic [63:0]       img_bytes;
  logic              img_mounted, img_readonly;
  logic [63:0]       img_size;
  logic [31:0]       sd_lba;
  logic              sd_rd, sd_wr, sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout, sd_buff_din;
  logic              sd_buff_wr;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd, mem_wr, mem_ready;
  logic [7:0]        mem_wdata, mem_rdata;
  logic              err_range;

  sd_block_responder #(.MEM_AW(MEM_AW), .ACK_DELAY(ACK_DELAY)) dut (
    .clk_sys(clk_sys), .RESET_n(RESET_n),
    .img_present(img_present), .img_ro_in(img_ro_in), .img_bytes(img_bytes),
    .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .err_range(err_range)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  int n_checks = 0;
  int n_err    = 0;

  // Set by the main sequence only.
  int                lat_max = 2;
  logic [MEM_AW-1:0] exp_base = '0;
  logic              exp_zero = 1'b0;

  // Backing store: data is address^0x5A, ready after 1..lat_max strobe cycles.
  int lat_left = 0;
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk_sys); #1;
      mem_ready = 1'b0;
      if (RESET_n && (mem_rd || mem_wr)) begin
        if (lat_left == 0) lat_left = $urandom_range(lat_max, 1);
        lat_left--;
        if (lat_left == 0) begin
          mem_ready = 1'b1;
          mem_rdata = mem_addr[7:0] ^ 8'h5A;
        end
      end else begin
        lat_left = 0;
      end
    end
  end

  // Initiator buffer: byte i holds i+1, one cycle read latency.
  logic [8:0] buf_a;
  initial begin
    sd_buff_din = 8'h00;
    forever begin
      @(negedge clk_sys);
      buf_a = sd_buff_addr;
      @(posedge clk_sys); #1;
      sd_buff_din = buf_a[7:0] + 8'd1;
    end
  end

  // Monitor: per-block counts reset at each ack rise, plus sticky error tallies.
  logic prev_ack = 1'b0;
  int n_rise = 0, n_fall = 0, ack_cyc = 0, blk_bw = 0, blk_mw = 0;
  int rd_next = 0, wr_next = 0;
  int bad_rd = 0, bad_wr = 0, bad_addr = 0, bad_proto = 0;
  int n_mount = 0, mount_in_ack = 0;
  logic [7:0] exp_byte;
  initial begin
    forever begin
      @(negedge clk_sys);
      if (sd_ack && !prev_ack) begin
        n_rise++;
        ack_cyc = 0; blk_bw = 0; blk_mw = 0; rd_next = 0; wr_next = 0;
      end
      if (!sd_ack && prev_ack) n_fall++;
      if (sd_ack) ack_cyc++;
      if (mem_rd && mem_ready && (mem_addr != exp_base + MEM_AW'(rd_next)))
        bad_addr++;
      if (sd_buff_wr) begin
        blk_bw++;
        exp_byte = exp_zero ? 8'h00 : (sd_buff_addr[7:0] ^ 8'h5A);
        if (sd_buff_addr != 9'(rd_next) || sd_buff_dout != exp_byte) bad_rd++;
        rd_next++;
      end
      if (mem_wr && mem_ready) begin
        blk_mw++;
        if (mem_addr != exp_base + MEM_AW'(wr_next) || mem_wdata != 8'(wr_next + 1))
          bad_wr++;
        wr_next++;
      end
      if (mem_rd && mem_wr) bad_proto++;
      if (sd_buff_wr && !sd_ack) bad_proto++;
      if (img_mounted) begin
        n_mount++;
        if (sd_ack) mount_in_ack++;
      end
      prev_ack = sd_ack;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic mount(input logic ro);
    img_present = 1'b0;
    repeat (2) @(negedge clk_sys);
    img_ro_in   = ro;
    img_bytes   = 64'd32768;
    img_present = 1'b1;
    repeat (3) @(negedge clk_sys);
  endtask

  // One request/ack handshake; lat = cycles from request to ack rise.
  task automatic run_block(input logic rd, input logic wr, input logic [31:0] lba,
                           input logic zero, output int lat);
    int wd;
    exp_base = MEM_AW'({lba, 9'b0});
    exp_zero = zero;
    sd_lba = lba; sd_rd = rd; sd_wr = wr;
    lat = 0;
    @(negedge clk_sys);
    while (!sd_ack && lat < 50) begin lat++; @(negedge clk_sys); end
    sd_rd = 1'b0; sd_wr = 1'b0;
    if (!sd_ack) begin
      check("ack_rise_timeout", 1, 0);
      return;
    end
    wd = 0;
    while (sd_ack && wd < 20000) begin wd++; @(negedge clk_sys); end
    if (sd_ack) check("ack_fall_timeout", 1, 0);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] lba;
    logic        ro;
    int          bw;
    int          mw;
    logic        zero;
    logic        err;
    int          ackc;   // 0: ack length not checked
  } vec_t;

  vec_t vt[9];

  initial begin
    int lat, s_rd, s_wr, s_ad, r0, m0, lat_bad, bw_bad, f0, wd;
    logic cur_ro;
    vt[0] = '{1'b1, 1'b0, 32'd3,   1'b0, 512, 0,   1'b0, 1'b0, 0};
    vt[1] = '{1'b0, 1'b1, 32'd63,  1'b0, 0,   512, 1'b0, 1'b0, 0};
    vt[2] = '{1'b1, 1'b1, 32'd5,   1'b0, 512, 0,   1'b0, 1'b0, 0};
    vt[3] = '{1'b1, 1'b0, 32'd64,  1'b0, 512, 0,   1'b1, 1'b1, 1025};
    vt[4] = '{1'b1, 1'b0, 32'd63,  1'b0, 512, 0,   1'b0, 1'b1, 0};
    vt[5] = '{1'b0, 1'b1, 32'd100, 1'b0, 0,   0,   1'b0, 1'b1, 1537};
    vt[6] = '{1'b0, 1'b1, 32'd1,   1'b1, 0,   0,   1'b0, 1'b0, 1537};
    vt[7] = '{1'b1, 1'b0, 32'd2,   1'b1, 512, 0,   1'b0, 1'b0, 0};
    vt[8] = '{1'b0, 1'b1, 32'd2,   1'b0, 0,   512, 1'b0, 1'b0, 0};

    RESET_n = 1'b0; img_present = 1'b0; img_ro_in = 1'b0; img_bytes = 64'd0;
    sd_lba = 32'd0; sd_rd = 1'b0; sd_wr = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("rst_ack", sd_ack, 0);
    check("rst_buff_wr", sd_buff_wr, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mounted", img_mounted, 0);
    check("rst_size", img_size, 0);
    check("rst_err", err_range, 0);
    check("rst_mem_addr", mem_addr, 0);
    RESET_n = 1'b1;
    @(negedge clk_sys);

    // Request with no image is never acked.
    r0 = n_rise;
    sd_lba = 32'd3; sd_rd = 1'b1;
    repeat (20) @(negedge clk_sys);
    sd_rd = 1'b0;
    check("noimg_rises", n_rise - r0, 0);
    check("noimg_err", err_range, 0);

    // First mount: pulse on the cycle after the rising edge, one cycle wide.
    img_bytes = 64'd32768; img_ro_in = 1'b0; img_present = 1'b1;
    @(negedge clk_sys);
    check("mount_pulse", img_mounted, 1);
    check("mount_size", img_size, 64'd32768);
    check("mount_ro", img_readonly, 0);
    @(negedge clk_sys);
    check("mount_pulse_end", img_mounted, 0);
    check("mount_count", n_mount, 1);

    // Table-driven block transfers.
    cur_ro = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (vt[i].ro != cur_ro) begin
        mount(vt[i].ro);
        cur_ro = vt[i].ro;
        check($sformatf("v%0d_readonly", i), img_readonly, vt[i].ro);
      end
      s_rd = bad_rd; s_wr = bad_wr; s_ad = bad_addr;
      run_block(vt[i].rd, vt[i].wr, vt[i].lba, vt[i].zero, lat);
      check($sformatf("v%0d_ack_lat", i), lat, ACK_DELAY);
      check($sformatf("v%0d_buff_wr", i), blk_bw, vt[i].bw);
      check($sformatf("v%0d_mem_wr", i), blk_mw, vt[i].mw);
      check($sformatf("v%0d_rd_data", i), bad_rd - s_rd, 0);
      check($sformatf("v%0d_wr_data", i), bad_wr - s_wr, 0);
      check($sformatf("v%0d_rd_addr", i), bad_addr - s_ad, 0);
      check($sformatf("v%0d_err", i), err_range, vt[i].err);
      if (vt[i].ackc != 0) check($sformatf("v%0d_ack_cycles", i), ack_cyc, vt[i].ackc);
    end

    // Back-to-back reads of lba 0..63, request one cycle after each ack fall.
    lat_max = 1;
    lat_bad = 0; bw_bad = 0; f0 = n_fall; s_rd = bad_rd; s_ad = bad_addr;
    for (int b = 0; b < 64; b++) begin
      run_block(1'b1, 1'b0, 32'(b), 1'b0, lat);
      if (lat != ACK_DELAY) lat_bad++;
      if (blk_bw != 512) bw_bad++;
    end
    check("b2b_blocks", n_fall - f0, 64);
    check("b2b_lat", lat_bad, 0);
    check("b2b_bytes", bw_bad, 0);
    check("b2b_rd_data", bad_rd - s_rd, 0);
    check("b2b_rd_addr", bad_addr - s_ad, 0);

    // Reset in the middle of a read at byte 200.
    lat_max = 2;
    exp_base = MEM_AW'({32'd4, 9'b0}); exp_zero = 1'b0;
    sd_lba = 32'd4; sd_rd = 1'b1;
    wd = 0;
    while (!(sd_buff_wr && sd_buff_addr == 9'd200) && wd < 5000) begin
      @(negedge clk_sys);
      if (sd_ack) sd_rd = 1'b0;
      wd++;
    end
    sd_rd = 1'b0;
    check("rst_mid_reached", sd_buff_wr, 1);
    RESET_n = 1'b0;
    #1;
    check("rst_mid_ack", sd_ack, 0);
    check("rst_mid_buff_wr", sd_buff_wr, 0);
    check("rst_mid_mem_rd", mem_rd, 0);
    check("rst_mid_size", img_size, 0);
    repeat (2) @(negedge clk_sys);
    RESET_n = 1'b1;
    mount(1'b0);
    s_rd = bad_rd; s_ad = bad_addr;
    run_block(1'b1, 1'b0, 32'd9, 1'b0, lat);
    check("post_rst_lat", lat, ACK_DELAY);
    check("post_rst_bytes", blk_bw, 512);
    check("post_rst_data", bad_rd - s_rd, 0);
    check("post_rst_addr", bad_addr - s_ad, 0);

    // Image toggled during a transfer: announce deferred to after ack fall.
    exp_base = MEM_AW'({32'd7, 9'b0}); exp_zero = 1'b0;
    s_rd = bad_rd;
    sd_lba = 32'd7; sd_rd = 1'b1;
    wd = 0;
    while (!sd_ack && wd < 50) begin @(negedge clk_sys); wd++; end
    sd_rd = 1'b0;
    check("defer_ack_rise", sd_ack, 1);
    repeat (10) @(negedge clk_sys);
    m0 = n_mount;
    img_present = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("defer_fall_size", img_size, 0);
    img_present = 1'b1;
    wd = 0;
    while (sd_ack && wd < 20000) begin @(negedge clk_sys); wd++; end
    check("defer_ack_fall", sd_ack, 0);
    repeat (3) @(negedge clk_sys);
    check("defer_mount_count", n_mount - m0, 1);
    check("defer_mount_in_ack", mount_in_ack, 0);
    check("defer_size", img_size, 64'd32768);
    check("defer_bytes", blk_bw, 512);
    check("defer_data", bad_rd - s_rd, 0);

    check("protocol", bad_proto, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
